control_pipe: RTL and testbench
===============================

// Module: control_pipe
// PURPOSE
//  Pipelined RV32I control unit. Decodes the ID-stage instruction, registers the control bundle into the ID/EX boundary, and resolves branches/jumps in EX.
//  Adds load-use stall, branch/jump flush and valid/ready backpressure. Covers all RV32I branches, slti/sltiu, auipc and full R/I decode.
//  Sits between the IF/ID register and the EX datapath.
// PARAMETERS
//  DATA_WIDTH  32  datapath width (ports unaffected; kept for top-level consistency)
//  REG_ADDR_W  5   register index width
//  ALU_CTRL_W  4   ALUControl width
// PORTS
//  clk              in   1           clock, rising edge
//  rst              in   1           synchronous reset, active-high
//  instr_i          in   32          ID-stage instruction
//  id_valid_i       in   1           instr_i valid
//  id_ready_o       out  1           ID may advance (0 = hold IF/ID)
//  ex_ready_i       in   1           EX accepts current bundle
//  ex_valid_o       out  1           EX bundle valid (0 = bubble)
//  ImmSrcD          out  3           comb. to sign-extend: 000 I, 001 S, 010 B, 011 J, 100 U
//  RegWriteE        out  1           write rd
//  ALUControlE      out  ALU_CTRL_W  add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1011, passB 1111
//  ALUSrcE          out  1           1 = imm operand
//  MemWriteE        out  1           store
//  ResultSrcE       out  2           00 ALU, 01 mem, 10 PC+4, 11 PC+imm (auipc)
//  AddressingControlE out 3          funct3 of load/store
//  rdE              out  REG_ADDR_W  destination register
//  zero_i, lt_i, ltu_i  in  1 each   EX ALU flags (rs1-rs2)
//  PCSrcE           out  2           comb.: 00 PC+4, 01 PC+imm, 10 ALU (jalr)
//  flush_o          out  1           comb.: kill IF/ID contents
//  illegal_o        out  1           sticky illegal-instruction flag
// BEHAVIOUR
//  - Reset: all E outputs 0, ex_valid_o=0, state RUN, illegal_o=0. Comb. outputs follow from reset state.
//  - Latency: 1 cycle ID->E. Decode of an unlisted opcode/funct yields an all-zero (NOP) bundle. No latches.
//  - Advance: EX register loads iff ex_ready_i | !ex_valid_o. Otherwise all E outputs hold, and id_ready_o=0.
//  - PCSrcE is gated by ex_valid_o & ex_ready_i.
//    - Branch conditions: beq zero, bne !zero, blt lt, bge !lt, bltu ltu, bgeu !ltu.
//    - jal -> 01; jalr -> 10.
//  - flush_o = (PCSrcE!=00). On flush the EX register loads a bubble (ex_valid_o=0) and the ID instruction is discarded.
//  - Load-use: EX holds a valid load with rdE!=0 and rdE==rs1D or rs2D, where the ID instruction uses that source.
//    - RUN -> LU_STALL. Bubble into EX; id_ready_o=0 for exactly 1 cycle.
//    - LU_STALL -> RUN unconditionally.
//  - Priority: rst > flush > EX hold > load-use > normal advance.
//  - id_valid_i=0 loads a bubble.
//  - rst mid-stall: returns to RUN, bubble in EX.
// CONFIGURATION
//  CONTROL_ILLEGAL_INSTR_EN defined:
//    - Undecodable valid instruction sets illegal_o (sticky until rst) and is converted to a bubble.
//  Undefined:
//    - illegal_o tied 0; undecodable instructions pass as NOP bundle with ex_valid_o=1.
// STRUCTURE
//  control_pkg:
//    - opcode localparams; enums alu_op_t, imm_src_t, result_src_t, pc_src_t
//    - ctrl_bundle_t struct (all E fields)
//  Sub-module control_decode: pure comb. instr -> ctrl_bundle_t + ImmSrc + uses_rs1/uses_rs2 + illegal.
//  control_pipe: EX register, FSM, branch resolve, hazard logic.
// TESTING
//  1. add x3,x1,x2 (0x002081B3) -> next cycle ex_valid_o=1, RegWriteE=1, ALUControlE=0000, rdE=3, ResultSrcE=00.
//  2. lw x5,0(x1) (0x0000A283) then add x6,x5,x5 (0x00528333)
//     -> one bubble (ex_valid_o=0), id_ready_o=0 for 1 cycle, then add issues.
//  3. beq in EX with zero_i=1 -> PCSrcE=01, flush_o=1; next cycle ex_valid_o=0. With zero_i=0 -> PCSrcE=00, no flush.
//  4. ex_ready_i=0 for 3 cycles with a valid sub bundle
//     -> E outputs stable, id_ready_o=0, PCSrcE=00; resumes on ex_ready_i=1.
//  5. rst asserted in LU_STALL -> next cycle ex_valid_o=0, all E outputs 0, id_ready_o=1.
//  6. instr 0xFFFFFFFF with CONTROL_ILLEGAL_INSTR_EN -> illegal_o=1 sticky, ex_valid_o=0.
//     Without the macro -> illegal_o=0, NOP bundle.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: shared opcodes, control encodings and the ID/EX control bundle
// for the pipelined RV32I control unit.
package control_pkg;

  localparam int unsigned RA_W = 5;

  // RV32I major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1011,
    ALU_PASSB = 4'b1111
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC4   = 2'b10,
    RES_PCIMM = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic              reg_write;
    alu_op_t           alu_ctrl;
    logic              alu_src;
    logic              mem_write;
    result_src_t       result_src;
    logic [2:0]        addr_ctrl;
    logic [RA_W-1:0]   rd;
    logic              is_load;
    logic              is_branch;
    logic [2:0]        br_f3;
    logic              is_jal;
    logic              is_jalr;
  } ctrl_bundle_t;

  // Branch condition from the EX ALU flags of rs1-rs2
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    logic t;
    case (f3)
      F3_BEQ:  t = zero;
      F3_BNE:  t = !zero;
      F3_BLT:  t = lt;
      F3_BGE:  t = !lt;
      F3_BLTU: t = ltu;
      F3_BGEU: t = !ltu;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: purely combinational RV32I decoder producing the control
// bundle, immediate format, source-register usage and an illegal flag.
module control_decode
  import control_pkg::*;
(
  input  logic [31:0]     instr,
  output ctrl_bundle_t    ctrl,
  output imm_src_t        imm_src,
  output logic [RA_W-1:0] rs1,
  output logic [RA_W-1:0] rs2,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic            illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Opcode/funct decode into the control bundle
  always_comb begin
    ctrl     = '0;
    imm_src  = IMM_I;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.rd        = rd;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: ctrl.alu_ctrl = ALU_ADD;
          {7'b0100000, 3'b000}: ctrl.alu_ctrl = ALU_SUB;
          {7'b0000000, 3'b001}: ctrl.alu_ctrl = ALU_SLL;
          {7'b0000000, 3'b010}: ctrl.alu_ctrl = ALU_SLT;
          {7'b0000000, 3'b011}: ctrl.alu_ctrl = ALU_SLTU;
          {7'b0000000, 3'b100}: ctrl.alu_ctrl = ALU_XOR;
          {7'b0000000, 3'b101}: ctrl.alu_ctrl = ALU_SRL;
          {7'b0100000, 3'b101}: ctrl.alu_ctrl = ALU_SRA;
          {7'b0000000, 3'b110}: ctrl.alu_ctrl = ALU_OR;
          {7'b0000000, 3'b111}: ctrl.alu_ctrl = ALU_AND;
          default:              illegal       = 1'b1;
        endcase
      end
      OP_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.rd        = rd;
        uses_rs1       = 1'b1;
        case (funct3)
          3'b000: ctrl.alu_ctrl = ALU_ADD;
          3'b010: ctrl.alu_ctrl = ALU_SLT;
          3'b011: ctrl.alu_ctrl = ALU_SLTU;
          3'b100: ctrl.alu_ctrl = ALU_XOR;
          3'b110: ctrl.alu_ctrl = ALU_OR;
          3'b111: ctrl.alu_ctrl = ALU_AND;
          3'b001: begin
            if (funct7 == 7'b0000000) ctrl.alu_ctrl = ALU_SLL;
            else                      illegal       = 1'b1;
          end
          default: begin
            if (funct7 == 7'b0000000)      ctrl.alu_ctrl = ALU_SRL;
            else if (funct7 == 7'b0100000) ctrl.alu_ctrl = ALU_SRA;
            else                           illegal       = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.addr_ctrl  = funct3;
        ctrl.rd         = rd;
        ctrl.is_load    = 1'b1;
        uses_rs1        = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
          default:                                illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.addr_ctrl = funct3;
        imm_src        = IMM_S;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010: illegal = 1'b0;
          default:                illegal = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        ctrl.alu_ctrl  = ALU_SUB;
        ctrl.is_branch = 1'b1;
        ctrl.br_f3     = funct3;
        imm_src        = IMM_B;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: illegal = 1'b0;
          default:                                          illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.rd         = rd;
        ctrl.is_jal     = 1'b1;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.rd         = rd;
        ctrl.is_jalr    = 1'b1;
        uses_rs1        = 1'b1;
        illegal         = (funct3 != 3'b000);
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
        ctrl.rd        = rd;
        imm_src        = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_PCIMM;
        ctrl.rd         = rd;
        imm_src         = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// control_pipe: RV32I control unit between IF/ID and EX. Registers the decoded
// bundle into ID/EX, resolves branches/jumps in EX, and handles load-use stall,
// flush and valid/ready backpressure.
// Optional feature macro: CONTROL_ILLEGAL_INSTR_EN (sticky illegal_o, illegal
// instructions become bubbles). Without it illegal_o is 0 and illegal
// instructions issue as a valid NOP bundle.
module control_pipe
  import control_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic                  ex_ready_i,
  output logic                  ex_valid_o,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  ALUSrcE,
  output logic                  MemWriteE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            AddressingControlE,
  output logic [REG_ADDR_W-1:0] rdE,
  input  logic                  zero_i,
  input  logic                  lt_i,
  input  logic                  ltu_i,
  output logic [1:0]            PCSrcE,
  output logic                  flush_o,
  output logic                  illegal_o
);

  if (DATA_WIDTH != 32 || REG_ADDR_W != RA_W || ALU_CTRL_W != 4) begin : g_param_check
    $error("control_pipe: unsupported parameter set");
  end

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_LU_STALL = 1'b1;

  ctrl_bundle_t    dec_ctrl;
  ctrl_bundle_t    dec_clean;
  imm_src_t        dec_imm;
  logic [RA_W-1:0] dec_rs1;
  logic [RA_W-1:0] dec_rs2;
  logic            dec_uses_rs1;
  logic            dec_uses_rs2;
  logic            dec_illegal;

  ctrl_bundle_t    ex_q;
  logic            ex_valid_q;
  logic [0:0]      state_q;

  pc_src_t         pc_sel;
  logic            advance;
  logic            load_use;
  logic            accept;
  logic            drop_illegal;

  control_decode u_decode (
    .instr    (instr_i),
    .ctrl     (dec_ctrl),
    .imm_src  (dec_imm),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .uses_rs1 (dec_uses_rs1),
    .uses_rs2 (dec_uses_rs2),
    .illegal  (dec_illegal)
  );

  assign ImmSrcD = dec_imm;

  // Bad-funct encodings of listed opcodes carry partial fields out of the
  // decoder; collapse every undecodable instruction to the all-zero NOP here.
  always_comb begin
    dec_clean = dec_ctrl;
    if (dec_illegal) dec_clean = '0;
  end

  // Branch/jump resolution, only for a valid bundle that EX is taking
  always_comb begin
    pc_sel = PC_PLUS4;
    if (ex_valid_q && ex_ready_i) begin
      if (ex_q.is_jalr)
        pc_sel = PC_ALU;
      else if (ex_q.is_jal ||
               (ex_q.is_branch && branch_taken(ex_q.br_f3, zero_i, lt_i, ltu_i)))
        pc_sel = PC_IMM;
    end
  end

  assign PCSrcE  = pc_sel;
  assign flush_o = (pc_sel != PC_PLUS4);

  // Hazard detection and ID handshake
  always_comb begin
    advance  = ex_ready_i || !ex_valid_q;
    load_use = (state_q == ST_RUN) && id_valid_i && ex_valid_q && ex_q.is_load &&
               (ex_q.rd != '0) &&
               ((dec_uses_rs1 && (dec_rs1 == ex_q.rd)) ||
                (dec_uses_rs2 && (dec_rs2 == ex_q.rd)));
    accept   = advance && !flush_o && !load_use && id_valid_i;
    id_ready_o = advance && (flush_o || !load_use);
  end

`ifdef CONTROL_ILLEGAL_INSTR_EN
  logic illegal_q;

  assign drop_illegal = dec_illegal;
  assign illegal_o    = illegal_q;

  // Sticky illegal flag, set when an undecodable instruction is accepted
  always_ff @(posedge clk) begin
    if (rst)                        illegal_q <= 1'b0;
    else if (accept && dec_illegal) illegal_q <= 1'b1;
  end
`else
  assign drop_illegal = 1'b0;
  assign illegal_o    = 1'b0;
`endif

  // ID/EX register: flush > hold > stall/bubble > issue
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else if (flush_o) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      if (accept && !drop_illegal) begin
        ex_q       <= dec_clean;
        ex_valid_q <= 1'b1;
      end else begin
        ex_q       <= '0;
        ex_valid_q <= 1'b0;
      end
    end
  end

  // Load-use FSM: one stall cycle, then back to RUN unconditionally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (advance && !flush_o && load_use) state_q <= ST_LU_STALL;
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign ex_valid_o         = ex_valid_q;
  assign RegWriteE          = ex_q.reg_write;
  assign ALUControlE        = ex_q.alu_ctrl;
  assign ALUSrcE            = ex_q.alu_src;
  assign MemWriteE          = ex_q.mem_write;
  assign ResultSrcE         = ex_q.result_src;
  assign AddressingControlE = ex_q.addr_ctrl;
  assign rdE                = ex_q.rd;

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed-vector bench for control_pipe.
module tb_control_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] instr_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic        ex_ready_i;
  logic        ex_valid_o;
  logic [2:0]  ImmSrcD;
  logic        RegWriteE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcE;
  logic        MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  AddressingControlE;
  logic [4:0]  rdE;
  logic        zero_i;
  logic        lt_i;
  logic        ltu_i;
  logic [1:0]  PCSrcE;
  logic        flush_o;
  logic        illegal_o;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  control_pipe #(.DATA_WIDTH(32), .REG_ADDR_W(5), .ALU_CTRL_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_i            (instr_i),
    .id_valid_i         (id_valid_i),
    .id_ready_o         (id_ready_o),
    .ex_ready_i         (ex_ready_i),
    .ex_valid_o         (ex_valid_o),
    .ImmSrcD            (ImmSrcD),
    .RegWriteE          (RegWriteE),
    .ALUControlE        (ALUControlE),
    .ALUSrcE            (ALUSrcE),
    .MemWriteE          (MemWriteE),
    .ResultSrcE         (ResultSrcE),
    .AddressingControlE (AddressingControlE),
    .rdE                (rdE),
    .zero_i             (zero_i),
    .lt_i               (lt_i),
    .ltu_i              (ltu_i),
    .PCSrcE             (PCSrcE),
    .flush_o            (flush_o),
    .illegal_o          (illegal_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock: returns 1 time unit after the next falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instr_i    = ins;
    id_valid_i = v;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        regw;
    logic [3:0]  alu;
    logic        src;
    logic        memw;
    logic [1:0]  res;
    logic [2:0]  addr;
    logic [4:0]  rd;
    logic [2:0]  imm;
  } vec_t;

  vec_t vecs[8];

  initial begin
    //           instr         regw  alu     src   memw  res    addr    rd      imm
    vecs[0] = '{32'h002081B3, 1'b1, 4'h0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd3, 3'd0}; // add x3,x1,x2
    vecs[1] = '{32'h402083B3, 1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd7, 3'd0}; // sub x7,x1,x2
    vecs[2] = '{32'h0000A283, 1'b1, 4'h0, 1'b1, 1'b0, 2'd1, 3'd2, 5'd5, 3'd0}; // lw x5,0(x1)
    vecs[3] = '{32'h0020A223, 1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 3'd2, 5'd0, 3'd1}; // sw x2,4(x1)
    vecs[4] = '{32'h0050A413, 1'b1, 4'h5, 1'b1, 1'b0, 2'd0, 3'd0, 5'd8, 3'd0}; // slti x8,x1,5
    vecs[5] = '{32'h0050B413, 1'b1, 4'h6, 1'b1, 1'b0, 2'd0, 3'd0, 5'd8, 3'd0}; // sltiu x8,x1,5
    vecs[6] = '{32'h00001217, 1'b1, 4'h0, 1'b1, 1'b0, 2'd3, 3'd0, 5'd4, 3'd4}; // auipc x4,1
    vecs[7] = '{32'h00028337, 1'b1, 4'hF, 1'b1, 1'b0, 2'd0, 3'd0, 5'd6, 3'd4}; // lui x6,0x28

    rst = 1'b1; instr_i = '0; id_valid_i = 1'b0; ex_ready_i = 1'b1;
    zero_i = 1'b0; lt_i = 1'b0; ltu_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid",   ex_valid_o,  0);
    check("rst_regw",    RegWriteE,   0);
    check("rst_alu",     ALUControlE, 0);
    check("rst_rd",      rdE,         0);
    check("rst_pcsrc",   PCSrcE,      0);
    check("rst_flush",   flush_o,     0);
    check("rst_illegal", illegal_o,   0);
    check("rst_ready",   id_ready_o,  1);
    rst = 1'b0;

    // decode table, back-to-back issue
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].instr, 1'b1);
      #1;
      check($sformatf("v%0d_imm", i), ImmSrcD, vecs[i].imm);
      check($sformatf("v%0d_rdy", i), id_ready_o, 1);
      tick();
      check($sformatf("v%0d_valid", i), ex_valid_o,         1);
      check($sformatf("v%0d_regw",  i), RegWriteE,          vecs[i].regw);
      check($sformatf("v%0d_alu",   i), ALUControlE,        vecs[i].alu);
      check($sformatf("v%0d_src",   i), ALUSrcE,            vecs[i].src);
      check($sformatf("v%0d_memw",  i), MemWriteE,          vecs[i].memw);
      check($sformatf("v%0d_res",   i), ResultSrcE,         vecs[i].res);
      check($sformatf("v%0d_addr",  i), AddressingControlE, vecs[i].addr);
      check($sformatf("v%0d_rd",    i), rdE,                vecs[i].rd);
    end

    // id_valid_i=0 gives a bubble
    drive(32'h002081B3, 1'b0);
    tick();
    check("bubble_valid", ex_valid_o, 0);
    check("bubble_regw",  RegWriteE,  0);

    // load-use: lw x5 then add x6,x5,x5
    drive(32'h0000A283, 1'b1);
    tick();
    drive(32'h00528333, 1'b1);
    #1;
    check("lu_rdy0", id_ready_o, 0);
    tick();
    check("lu_bubble", ex_valid_o, 0);
    check("lu_regw",   RegWriteE,  0);
    check("lu_rdy1",   id_ready_o, 1);
    tick();
    check("lu_issue_valid", ex_valid_o, 1);
    check("lu_issue_rd",    rdE,        6);

    // load to x0 never stalls
    drive(32'h0000A003, 1'b1);
    tick();
    drive(32'h00000333, 1'b1);
    #1;
    check("lu_x0_rdy", id_ready_o, 1);
    tick();
    check("lu_x0_valid", ex_valid_o, 1);
    check("lu_x0_rd",    rdE,        6);

    // lui does not read rs1 even when its bits alias the load rd
    drive(32'h0000A283, 1'b1);
    tick();
    drive(32'h00028337, 1'b1);
    #1;
    check("lu_lui_rdy", id_ready_o, 1);
    tick();
    check("lu_lui_alu", ALUControlE, 4'hF);

    // beq taken, gated first by ex_ready_i
    drive(32'h00208463, 1'b1);
    tick();
    drive(32'h002081B3, 1'b1);
    ex_ready_i = 1'b0; zero_i = 1'b1;
    #1;
    check("beq_hold_pc",    PCSrcE,  0);
    check("beq_hold_flush", flush_o, 0);
    ex_ready_i = 1'b1;
    #1;
    check("beq_t_pc",    PCSrcE,  1);
    check("beq_t_flush", flush_o, 1);
    tick();
    check("beq_t_bubble", ex_valid_o, 0);
    zero_i = 1'b0;

    // beq not taken, following add issues
    drive(32'h00208463, 1'b1);
    tick();
    drive(32'h002081B3, 1'b1);
    #1;
    check("beq_nt_pc",    PCSrcE,  0);
    check("beq_nt_flush", flush_o, 0);
    tick();
    check("beq_nt_valid", ex_valid_o, 1);
    check("beq_nt_rd",    rdE,        3);

    // bne taken on !zero
    drive(32'h00209463, 1'b1);
    tick();
    id_valid_i = 1'b0;
    #1;
    check("bne_pc", PCSrcE, 1);
    tick();

    // bgeu: ltu=1 not taken, ltu=0 taken
    drive(32'h0020F463, 1'b1);
    tick();
    id_valid_i = 1'b0; ltu_i = 1'b1;
    #1;
    check("bgeu_nt_pc", PCSrcE, 0);
    ltu_i = 1'b0;
    #1;
    check("bgeu_t_pc", PCSrcE, 1);
    tick();

    // jal x1 / jalr x0,0(x1)
    drive(32'h000000EF, 1'b1);
    tick();
    id_valid_i = 1'b0;
    #1;
    check("jal_pc",   PCSrcE,     1);
    check("jal_res",  ResultSrcE, 2);
    check("jal_rd",   rdE,        1);
    check("jal_regw", RegWriteE,  1);
    tick();
    drive(32'h00008067, 1'b1);
    tick();
    id_valid_i = 1'b0;
    #1;
    check("jalr_pc",  PCSrcE,     2);
    check("jalr_res", ResultSrcE, 2);
    check("jalr_src", ALUSrcE,    1);
    tick();

    // EX backpressure with a sub bundle
    drive(32'h402083B3, 1'b1);
    tick();
    ex_ready_i = 1'b0;
    drive(32'h002081B3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold%0d_valid", i), ex_valid_o,  1);
      check($sformatf("hold%0d_alu",   i), ALUControlE, 1);
      check($sformatf("hold%0d_rd",    i), rdE,         7);
      check($sformatf("hold%0d_rdy",   i), id_ready_o,  0);
      check($sformatf("hold%0d_pc",    i), PCSrcE,      0);
      tick();
    end
    ex_ready_i = 1'b1;
    #1;
    check("hold_release_rdy", id_ready_o, 1);
    tick();
    check("hold_resume_rd",  rdE,         3);
    check("hold_resume_alu", ALUControlE, 0);

    // reset while in LU_STALL
    drive(32'h0000A283, 1'b1);
    tick();
    drive(32'h00528333, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    check("rststall_valid", ex_valid_o,         0);
    check("rststall_regw",  RegWriteE,          0);
    check("rststall_alu",   ALUControlE,        0);
    check("rststall_rd",    rdE,                0);
    check("rststall_res",   ResultSrcE,         0);
    check("rststall_addr",  AddressingControlE, 0);
    check("rststall_rdy",   id_ready_o,         1);
    rst = 1'b0;
    id_valid_i = 1'b0;
    tick();

    // undecodable instruction
    drive(32'hFFFFFFFF, 1'b1);
    tick();
`ifdef CONTROL_ILLEGAL_INSTR_EN
    check("ill_flag",  illegal_o,  1);
    check("ill_valid", ex_valid_o, 0);
    drive(32'h002081B3, 1'b1);
    tick();
    check("ill_sticky",     illegal_o,  1);
    check("ill_next_valid", ex_valid_o, 1);
`else
    check("ill_flag",  illegal_o,   0);
    check("ill_valid", ex_valid_o,  1);
    check("ill_regw",  RegWriteE,   0);
    check("ill_alu",   ALUControlE, 0);
    check("ill_rd",    rdE,         0);
`endif
    id_valid_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
